// File: rtl/factor_pkg.sv
// Shared types and candidate-range constants for the factor search engine.
// FACTOR_ODD_ONLY_EN restricts the search to odd candidates starting at 3.
package factor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_CMP
  } state_e;

`ifdef FACTOR_ODD_ONLY_EN
  localparam int CAND_MIN  = 3;
  localparam int CAND_STEP = 2;
`else
  localparam int CAND_MIN  = 2;
  localparam int CAND_STEP = 1;
`endif

  // Largest candidate for an operand of width w: all ones.
  function automatic int candMax(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/factor_search_engine_shift_add_mul.sv
// Shift-add multiplier: accumulates one partial product of a*b per enabled cycle, LSB of b first.
module shift_add_mul #(
  parameter int A_W = 7,
  parameter int B_W = 4,
  parameter int P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           en_i,
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [P_W-1:0] acc_o,
  output logic           last_bit_o
);

  localparam int IDX_W = (B_W > 1) ? $clog2(B_W) : 1;

  logic [P_W-1:0]   acc_q;
  logic [IDX_W-1:0] idx_q;
  logic [P_W-1:0]   partial;

  assign partial    = b_i[idx_q] ? (P_W'(a_i) << idx_q) : '0;
  assign last_bit_o = (idx_q == IDX_W'(B_W - 1));
  assign acc_o      = acc_q;

  // Clear wins over enable so a new candidate always starts from a zero sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      idx_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
      idx_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + partial;
      idx_q <= idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/factor_search_engine.sv
// Brute-force factor search: enumerates a/b candidates (b outer, a inner) and reports the first
// pair whose product equals the target. FACTOR_ODD_ONLY_EN selects odd-only candidates.
module factor_search_engine
  import factor_pkg::*;
#(
  parameter int A_W = 7,
  parameter int B_W = 4,
  parameter int P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [P_W-1:0] target,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [A_W-1:0] a_out,
  output logic [B_W-1:0] b_out
);

  localparam logic [A_W-1:0] A_MIN  = A_W'(CAND_MIN);
  localparam logic [A_W-1:0] A_MAX  = A_W'(candMax(A_W));
  localparam logic [A_W-1:0] A_STEP = A_W'(CAND_STEP);
  localparam logic [B_W-1:0] B_MIN  = B_W'(CAND_MIN);
  localparam logic [B_W-1:0] B_MAX  = B_W'(candMax(B_W));
  localparam logic [B_W-1:0] B_STEP = B_W'(CAND_STEP);

  state_e         state_q, state_d;
  logic [P_W-1:0] target_q, target_d;
  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  logic [A_W-1:0] a_out_q, a_out_d;
  logic [B_W-1:0] b_out_q, b_out_d;
  logic           found_q, found_d;
  logic           done_q, done_d;

  logic           mul_clr;
  logic           mul_en;
  logic [P_W-1:0] acc;
  logic           last_bit;

  shift_add_mul #(
    .A_W(A_W),
    .B_W(B_W),
    .P_W(P_W)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (mul_clr),
    .en_i      (mul_en),
    .a_i       (a_q),
    .b_i       (b_q),
    .acc_o     (acc),
    .last_bit_o(last_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_out_q  <= '0;
      b_out_q  <= '0;
      found_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_out_q  <= a_out_d;
      b_out_q  <= b_out_d;
      found_q  <= found_d;
      done_q   <= done_d;
    end
  end

  // Abort is checked first in MUL and CMP so it beats a same-cycle match.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    a_d      = a_q;
    b_d      = b_q;
    a_out_d  = a_out_q;
    b_out_d  = b_out_q;
    found_d  = found_q;
    done_d   = 1'b0;
    mul_clr  = 1'b0;
    mul_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d = target;
          a_d      = A_MIN;
          b_d      = B_MIN;
          found_d  = 1'b0;
          mul_clr  = 1'b1;
          state_d  = ST_MUL;
        end
      end
      ST_MUL: begin
        if (abort) begin
          found_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          mul_en = 1'b1;
          if (last_bit) begin
            state_d = ST_CMP;
          end
        end
      end
      ST_CMP: begin
        if (abort) begin
          found_d = 1'b0;
          state_d = ST_IDLE;
        end else if (acc == target_q) begin
          found_d = 1'b1;
          a_out_d = a_q;
          b_out_d = b_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if ((a_q == A_MAX) && (b_q == B_MAX)) begin
          found_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          // Compare against MAX-STEP so the increment never wraps the a register.
          if (a_q > (A_MAX - A_STEP)) begin
            a_d = A_MIN;
            b_d = b_q + B_STEP;
          end else begin
            a_d = a_q + A_STEP;
          end
          mul_clr = 1'b1;
          state_d = ST_MUL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign found = found_q;
  assign a_out = a_out_q;
  assign b_out = b_out_q;

endmodule

// File: tb/tb_factor_search_engine.sv
// Self-checking bench for factor_search_engine: directed and random targets against an
// enumeration model; follows FACTOR_ODD_ONLY_EN the same way the design does.
module tb_factor_search_engine;

  localparam int A_W = 7;
  localparam int B_W = 4;
  localparam int P_W = A_W + B_W;
`ifdef FACTOR_ODD_ONLY_EN
  localparam int MIN_V  = 3;
  localparam int STEP_V = 2;
`else
  localparam int MIN_V  = 2;
  localparam int STEP_V = 1;
`endif
  localparam int A_MAX_V = (1 << A_W) - 1;
  localparam int B_MAX_V = (1 << B_W) - 1;
  localparam int CPC     = B_W + 1;
  localparam int LIMIT   = 9000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [P_W-1:0] target = '0;
  logic           busy;
  logic           done;
  logic           found;
  logic [A_W-1:0] a_out;
  logic [B_W-1:0] b_out;

  int errorCount = 0;
  int checkCount = 0;
  int lastA = 0;
  int lastB = 0;

  factor_search_engine #(
    .A_W(A_W),
    .B_W(B_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .target(target),
    .busy  (busy),
    .done  (done),
    .found (found),
    .a_out (a_out),
    .b_out (b_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: walk the candidate list in order and count until the first product match.
  task automatic refSearch(input int tgt, output int k, output bit f, output int fa, output int fb);
    k  = 0;
    f  = 1'b0;
    fa = lastA;
    fb = lastB;
    for (int b = MIN_V; b <= B_MAX_V && !f; b += STEP_V) begin
      for (int a = MIN_V; a <= A_MAX_V && !f; a += STEP_V) begin
        k++;
        if (a * b == tgt) begin
          f  = 1'b1;
          fa = a;
          fb = b;
        end
      end
    end
  endtask

  task automatic applyStimulus(input int tgt, input int pulseAt, input int pulseTgt);
    int k, fa, fb, cyc;
    bit f, seen;
    refSearch(tgt, k, f, fa, fb);
    @(negedge clk);
    start  = 1'b1;
    target = P_W'(tgt);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busyAfterStart", int'(busy), 1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < LIMIT) begin
      if (cyc == pulseAt) begin
        start  = 1'b1;
        target = P_W'(pulseTgt);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (done) seen = 1'b1;
    end
    checkOutput("doneSeen", int'(seen), 1);
    checkOutput("doneCycle", cyc, k * CPC);
    checkOutput("found", int'(found), int'(f));
    checkOutput("aOut", int'(a_out), fa);
    checkOutput("bOut", int'(b_out), fb);
    checkOutput("busyAtDone", int'(busy), 0);
    if (f) begin
      lastA = fa;
      lastB = fb;
    end
    @(posedge clk);
    #1;
    checkOutput("donePulse", int'(done), 0);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "Busy"}, int'(busy), 0);
    checkOutput({tag, "Done"}, int'(done), 0);
    checkOutput({tag, "Found"}, int'(found), 0);
    checkOutput({tag, "AOut"}, int'(a_out), 0);
    checkOutput({tag, "BOut"}, int'(b_out), 0);
  endtask

  initial begin
    int cyc, av, bv;
    bit sawDone;
    #1;
    checkIdleZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(6, -1, 0);
    applyStimulus(143, -1, 0);
    applyStimulus(127, -1, 0);
    applyStimulus(0, -1, 0);

    // Abort mid-search: idle next cycle, no done, result registers keep their values.
    @(negedge clk);
    start  = 1'b1;
    target = P_W'(143);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (cyc = 0; cyc < 50; cyc++) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortFound", int'(found), 0);
    checkOutput("abortAOut", int'(a_out), lastA);
    checkOutput("abortBOut", int'(b_out), lastB);
    sawDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("abortQuiet", int'(sawDone), 0);
    applyStimulus(6, -1, 0);

    // A start pulse while busy must not restart the search.
    applyStimulus(6, 3, 143);

    // Asynchronous reset while multiplying.
    @(negedge clk);
    start  = 1'b1;
    target = P_W'(143);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdleZero("asyncRst");
    lastA = 0;
    lastB = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(6, -1, 0);

    for (int i = 0; i < 4; i++) begin
      av = MIN_V + STEP_V * $urandom_range(0, (A_MAX_V - MIN_V) / STEP_V);
      bv = MIN_V + STEP_V * $urandom_range(0, (B_MAX_V - MIN_V) / STEP_V);
      applyStimulus(av * bv, -1, 0);
    end
    applyStimulus($urandom_range(0, (1 << P_W) - 1), -1, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
